// File: rtl/alu_defs_pkg.sv
// Shared ALU definitions: opcode encodings, opcode type and flag bit positions.
// Flags are packed as {N,Z,C,V}.
package alu_defs;

    typedef logic [1:0] alu_op_t;

    localparam alu_op_t ARITH_ADD = 2'b00;
    localparam alu_op_t ARITH_SUB = 2'b01;
    localparam alu_op_t AND_      = 2'b10;
    localparam alu_op_t OR_       = 2'b11;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

endpackage

// File: rtl/alu_core.sv
// Combinational ALU: AND, OR, ADD, SUB with NZCV flags, all modulo 2^WIDTH.
module alu_core
    import alu_defs::*;
#(
    parameter int WIDTH = 32
) (
    input  alu_op_t            op,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic [WIDTH-1:0]   result,
    output logic [3:0]         flags
);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] diff;
    logic           carry;
    logic           overflow;

    // SUB uses a + ~b + 1, so the carry out doubles as "no borrow".
    always_comb begin
        sum      = {1'b0, a} + {1'b0, b};
        diff     = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
        result   = '0;
        carry    = 1'b0;
        overflow = 1'b0;
        case (op)
            ARITH_ADD: begin
                result   = sum[WIDTH-1:0];
                carry    = sum[WIDTH];
                overflow = (a[WIDTH-1] == b[WIDTH-1]) && (result[WIDTH-1] != a[WIDTH-1]);
            end
            ARITH_SUB: begin
                result   = diff[WIDTH-1:0];
                carry    = diff[WIDTH];
                overflow = (a[WIDTH-1] != b[WIDTH-1]) && (result[WIDTH-1] != a[WIDTH-1]);
            end
            AND_:    result = a & b;
            default: result = a | b;
        endcase
        flags         = '0;
        flags[FLAG_N] = result[WIDTH-1];
        flags[FLAG_Z] = (result == '0);
        flags[FLAG_C] = carry;
        flags[FLAG_V] = overflow;
    end

endmodule

// File: rtl/alu_exec_stage.sv
// Two-register ALU execution stage: operand register (S1) feeding result register (S2),
// valid/ready on both sides, plus a wrapping count of completed output handshakes.
module alu_exec_stage
    import alu_defs::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  alu_op_t            in_op,
    input  logic [WIDTH-1:0]   in_a,
    input  logic [WIDTH-1:0]   in_b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_result,
    output logic [3:0]         out_flags,
    output logic [CNT_W-1:0]   done_count
);

    alu_op_t            op_q, op_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic               s1_valid_q, s1_valid_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic [3:0]         flags_q, flags_d;
    logic               s2_valid_q, s2_valid_d;
    logic [CNT_W-1:0]   count_q, count_d;

    logic [WIDTH-1:0]   alu_result;
    logic [3:0]         alu_flags;
    logic               s2_free;
    logic               s1_adv;
    logic               s1_load;
    logic               out_fire;

    alu_core #(.WIDTH(WIDTH)) u_alu_core (
        .op     (op_q),
        .a      (a_q),
        .b      (b_q),
        .result (alu_result),
        .flags  (alu_flags)
    );

    // S2 frees up in the same cycle it is drained, giving 1 op/cycle throughput.
    always_comb begin
        s2_free  = !s2_valid_q || out_ready;
        s1_adv   = s1_valid_q && s2_free;
        in_ready = !s1_valid_q || s2_free;
        s1_load  = in_valid && in_ready;
        out_fire = s2_valid_q && out_ready;

        op_d       = op_q;
        a_d        = a_q;
        b_d        = b_q;
        result_d   = result_q;
        flags_d    = flags_q;
        s1_valid_d = s1_valid_q;
        s2_valid_d = s2_valid_q;
        count_d    = count_q + CNT_W'(out_fire);

        if (s1_load) begin
            op_d = in_op;
            a_d  = in_a;
            b_d  = in_b;
        end
        if (s1_load) begin
            s1_valid_d = 1'b1;
        end else if (s1_adv) begin
            s1_valid_d = 1'b0;
        end

        if (s1_adv) begin
            result_d   = alu_result;
            flags_d    = alu_flags;
            s2_valid_d = 1'b1;
        end else if (out_fire) begin
            s2_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q       <= '0;
            a_q        <= '0;
            b_q        <= '0;
            s1_valid_q <= 1'b0;
            result_q   <= '0;
            flags_q    <= '0;
            s2_valid_q <= 1'b0;
            count_q    <= '0;
        end else begin
            op_q       <= op_d;
            a_q        <= a_d;
            b_q        <= b_d;
            s1_valid_q <= s1_valid_d;
            result_q   <= result_d;
            flags_q    <= flags_d;
            s2_valid_q <= s2_valid_d;
            count_q    <= count_d;
        end
    end

    assign out_valid  = s2_valid_q;
    assign out_result = result_q;
    assign out_flags  = flags_q;
    assign done_count = count_q;

endmodule

// File: tb/tb_alu_exec_stage.sv
// Bench for alu_exec_stage at WIDTH=8, CNT_W=4: directed scenario tasks plus a
// scoreboard that predicts every output handshake from the accepted inputs.
module tb_alu_exec_stage;
    import alu_defs::*;

    localparam int WIDTH = 8;
    localparam int CNT_W = 4;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               in_valid = 1'b0;
    logic               in_ready;
    alu_op_t            in_op = ARITH_ADD;
    logic [WIDTH-1:0]   in_a = '0;
    logic [WIDTH-1:0]   in_b = '0;
    logic               out_valid;
    logic               out_ready = 1'b0;
    logic [WIDTH-1:0]   out_result;
    logic [3:0]         out_flags;
    logic [CNT_W-1:0]   done_count;

    int                 tests_run = 0;
    int                 tests_failed = 0;
    logic [11:0]        sb[$];
    logic [CNT_W-1:0]   exp_count = '0;

    alu_exec_stage #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_a       (in_a),
        .in_b       (in_b),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_flags  (out_flags),
        .done_count (done_count)
    );

    always #5 clk = ~clk;

    // Reference model from integer arithmetic; returns {result, N, Z, C, V}.
    function automatic logic [11:0] model(alu_op_t op, logic [7:0] a, logic [7:0] b);
        int ua, ub, sa, sbv, r;
        logic [7:0] res;
        logic c, v;
        ua = int'(a);
        ub = int'(b);
        sa = int'($signed(a));
        sbv = int'($signed(b));
        c = 1'b0;
        v = 1'b0;
        case (op)
            ARITH_ADD: begin
                r = ua + ub;
                res = r[7:0];
                c = (r > 255);
                v = ((sa + sbv) > 127) || ((sa + sbv) < -128);
            end
            ARITH_SUB: begin
                r = ua - ub;
                res = r[7:0];
                c = (ua >= ub);
                v = ((sa - sbv) > 127) || ((sa - sbv) < -128);
            end
            AND_:    res = a & b;
            default: res = a | b;
        endcase
        return {res, res[7], (res == 8'h00), c, v};
    endfunction

    // Scoreboard: sample mid-cycle, predict on accept, compare on output handshake.
    always @(negedge clk) begin
        if (rst_n) begin
            tests_run++;
            if (done_count !== exp_count) begin
                tests_failed++;
                $display("[TB] FAIL sb_done_count: got %0d want %0d", done_count, exp_count);
            end
            if (out_valid && out_ready) begin
                tests_run++;
                if (sb.size() == 0) begin
                    tests_failed++;
                    $display("[TB] FAIL sb_unexpected_output: got %h/%b with nothing pending", out_result, out_flags);
                end else begin
                    logic [11:0] exp;
                    exp = sb.pop_front();
                    if ({out_result, out_flags} !== exp) begin
                        tests_failed++;
                        $display("[TB] FAIL sb_result: got %h/%b want %h/%b", out_result, out_flags, exp[11:4], exp[3:0]);
                    end
                end
                exp_count = exp_count + 1'b1;
            end
            if (in_valid && in_ready) begin
                sb.push_back(model(in_op, in_a, in_b));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic v, input alu_op_t op, input logic [7:0] a, input logic [7:0] b);
        in_valid = v;
        in_op = op;
        in_a = a;
        in_b = b;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        applyStimulus(1'b0, ARITH_ADD, 8'h00, 8'h00);
        out_ready = 1'b0;
        step();
        step();
        tests_run++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_handshake: got in_ready=%b out_valid=%b want 1/0", in_ready, out_valid);
        end
        tests_run++;
        if (out_result !== 8'h00 || out_flags !== 4'h0 || done_count !== 4'h0) begin
            tests_failed++;
            $display("[TB] FAIL reset_data: got %h/%b/%0d want 00/0000/0", out_result, out_flags, done_count);
        end
        sb.delete();
        exp_count = '0;
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_add_overflow();
        out_ready = 1'b1;
        applyStimulus(1'b1, ARITH_ADD, 8'h7F, 8'h01);
        step();
        applyStimulus(1'b0, ARITH_ADD, 8'h00, 8'h00);
        step();
        tests_run++;
        if (out_valid !== 1'b1 || out_result !== 8'h80 || out_flags !== 4'b1001) begin
            tests_failed++;
            $display("[TB] FAIL add_overflow: got v=%b %h/%b want 1 80/1001", out_valid, out_result, out_flags);
        end
        step();
        tests_run++;
        if (done_count !== 4'd1 || out_valid !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL add_count: got count=%0d v=%b want 1/0", done_count, out_valid);
        end
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        applyStimulus(1'b1, ARITH_SUB, 8'h05, 8'h05);
        step();
        applyStimulus(1'b1, ARITH_SUB, 8'h00, 8'h01);
        step();
        applyStimulus(1'b0, ARITH_ADD, 8'h00, 8'h00);
        tests_run++;
        if (out_valid !== 1'b1 || out_result !== 8'h00 || out_flags !== 4'b0110) begin
            tests_failed++;
            $display("[TB] FAIL sub_equal: got v=%b %h/%b want 1 00/0110", out_valid, out_result, out_flags);
        end
        step();
        tests_run++;
        if (out_valid !== 1'b1 || out_result !== 8'hFF || out_flags !== 4'b1000) begin
            tests_failed++;
            $display("[TB] FAIL sub_borrow: got v=%b %h/%b want 1 FF/1000", out_valid, out_result, out_flags);
        end
        step();
    endtask

    task automatic test_logic();
        out_ready = 1'b1;
        applyStimulus(1'b1, AND_, 8'hF0, 8'h0F);
        step();
        applyStimulus(1'b1, OR_, 8'hF0, 8'h0F);
        step();
        applyStimulus(1'b0, ARITH_ADD, 8'h00, 8'h00);
        tests_run++;
        if (out_result !== 8'h00 || out_flags !== 4'b0100) begin
            tests_failed++;
            $display("[TB] FAIL and_op: got %h/%b want 00/0100", out_result, out_flags);
        end
        step();
        tests_run++;
        if (out_result !== 8'hFF || out_flags !== 4'b1000) begin
            tests_failed++;
            $display("[TB] FAIL or_op: got %h/%b want FF/1000", out_result, out_flags);
        end
        step();
    endtask

    task automatic test_stall();
        out_ready = 1'b0;
        applyStimulus(1'b1, ARITH_ADD, 8'h10, 8'h20);
        step();
        tests_run++;
        if (in_ready !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL stall_second_accept: got in_ready=%b want 1", in_ready);
        end
        applyStimulus(1'b1, ARITH_SUB, 8'h03, 8'h05);
        step();
        applyStimulus(1'b1, OR_, 8'h80, 8'h01);
        for (int i = 0; i < 3; i++) begin
            tests_run++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_result !== 8'h30 || out_flags !== 4'b0000) begin
                tests_failed++;
                $display("[TB] FAIL stall_hold: got rdy=%b v=%b %h/%b want 0 1 30/0000", in_ready, out_valid, out_result, out_flags);
            end
            step();
        end
        out_ready = 1'b1;
        step();
        applyStimulus(1'b0, ARITH_ADD, 8'h00, 8'h00);
        tests_run++;
        if (out_valid !== 1'b1 || out_result !== 8'hFE || out_flags !== 4'b1000) begin
            tests_failed++;
            $display("[TB] FAIL stall_drain_b: got v=%b %h/%b want 1 FE/1000", out_valid, out_result, out_flags);
        end
        step();
        tests_run++;
        if (out_valid !== 1'b1 || out_result !== 8'h81 || out_flags !== 4'b1000) begin
            tests_failed++;
            $display("[TB] FAIL stall_drain_c: got v=%b %h/%b want 1 81/1000", out_valid, out_result, out_flags);
        end
        step();
        tests_run++;
        if (out_valid !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL stall_empty: got v=%b want 0", out_valid);
        end
    endtask

    task automatic test_reset_midflight();
        out_ready = 1'b0;
        applyStimulus(1'b1, ARITH_ADD, 8'h01, 8'h02);
        step();
        applyStimulus(1'b1, ARITH_ADD, 8'h03, 8'h04);
        step();
        applyStimulus(1'b0, ARITH_ADD, 8'h00, 8'h00);
        tests_run++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL midflight_full: got v=%b rdy=%b want 1/0", out_valid, in_ready);
        end
        rst_n = 1'b0;
        #1;
        tests_run++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || done_count !== 4'd0) begin
            tests_failed++;
            $display("[TB] FAIL midflight_reset: got v=%b rdy=%b cnt=%0d want 0/1/0", out_valid, in_ready, done_count);
        end
        sb.delete();
        exp_count = '0;
        step();
        rst_n = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            tests_run++;
            if (out_valid !== 1'b0) begin
                tests_failed++;
                $display("[TB] FAIL midflight_stale: got v=%b %h want no output", out_valid, out_result);
            end
        end
    endtask

    task automatic test_count_wrap();
        out_ready = 1'b1;
        for (int i = 0; i < (1 << CNT_W) + 3; i++) begin
            applyStimulus(1'b1, alu_op_t'($urandom_range(0, 3)), 8'($urandom), 8'($urandom));
            step();
        end
        applyStimulus(1'b0, ARITH_ADD, 8'h00, 8'h00);
        step();
        step();
        tests_run++;
        if (done_count !== 4'd3 || sb.size() != 0) begin
            tests_failed++;
            $display("[TB] FAIL count_wrap: got cnt=%0d pending=%0d want 3/0", done_count, sb.size());
        end
    endtask

    initial begin
        test_reset();
        test_add_overflow();
        test_back_to_back();
        test_logic();
        test_stall();
        test_reset_midflight();
        test_count_wrap();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/alu_exec_stage.md
# alu_exec_stage

Registered execution stage wrapping the ALU operations AND, OR, ADD and SUB. It accepts operand/opcode transactions from the decode/issue side over a valid/ready handshake and computes result plus NZCV flags through a two-register pipeline. It presents them to the writeback side over a second valid/ready handshake and counts completed operations.

## Interface
- WIDTH, 32, operand and result width in bits (≥ 2)
- CNT_W, 16, width of completed-operation counter
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous reset, active-low
- in_valid  input  1  upstream transaction present
- in_ready  output  1  stage can accept this cycle
- in_op  input  2  opcode: ARITH_ADD, ARITH_SUB, AND_, OR_ (shared package encodings)
- in_a  input  WIDTH  operand A
- in_b  input  WIDTH  operand B
- out_valid  output  1  result present
- out_ready  input  1  downstream accepts this cycle
- out_result  output  WIDTH  result
- out_flags  output  4  {N,Z,C,V}
- done_count  output  CNT_W  count of completed output handshakes

## Operation
- Stage 1 (S1) holds the operand register: op, a, b, valid bit. Captures inputs on in_valid && in_ready.
- Stage 2 (S2) holds the result register: result, flags, valid bit. Loads ALU output computed from S1 when S1 advances.
- Advance rules:
  - s2_free = !s2_valid || out_ready
  - s1 advances when s1_valid && s2_free
  - in_ready = !s1_valid || s2_free
- out_valid = s2_valid. Output holds result and flags stable while out_valid && !out_ready.
- Arithmetic, all modulo 2^WIDTH:
  - ADD: result = a+b. C = carry out. V = (a[MSB]==b[MSB]) && (result[MSB]!=a[MSB]).
  - SUB: result = a + ~b + 1. C = 1 when no borrow (a ≥ b unsigned). V = (a[MSB]!=b[MSB]) && (result[MSB]!=a[MSB]).
  - AND / OR: bitwise; C = 0, V = 0.
  - All ops: N = result[MSB]; Z = (result == 0).
- done_count increments by 1 on each out_valid && out_ready. It wraps from all-ones to 0.
- Simultaneous accept and output in the same cycle is legal and sustains throughput of 1 op/cycle.
- Data registers load only on their stage's enable. They do not change when no transfer occurs.

## Timing
- Latency: a transaction accepted at edge k appears on out_valid after edge k+1, i.e. it is visible in the cycle following the next edge (2 register stages).
- Throughput: 1 per cycle while out_ready is high.
- Reset (rst_n low, asynchronous): all valid bits 0, all data/flag registers 0, done_count 0. Outputs while in reset: in_ready = 1, out_valid = 0, out_result = 0, out_flags = 0.
- Reset mid-operation discards in-flight S1/S2 contents; no output is produced for them.
- in_ready depends combinationally on out_ready (one-gate path). This is accepted; there is no skid buffer.
- Full stall (out_ready low): at most two transactions are held (S1 and S2), after which in_ready = 0.
- Upstream must hold in_op/in_a/in_b stable while in_valid && !in_ready.

## Structure
- Shared package alu_defs: keep existing opcode parameters. Add flag bit indices FLAG_N = 3, FLAG_Z = 2, FLAG_C = 1, FLAG_V = 0, and a 2-bit alu_op_t typedef.
- One combinational sub-module, alu_core: (op, a, b) → (result, flags), parameterized by WIDTH. alu_exec_stage instantiates it between S1 and S2 and contains all sequential logic.

## Test plan
All cases use WIDTH = 8.
- ADD 0x7F + 0x01, out_ready = 1 → after 2 edges result 0x80, flags N=1 Z=0 C=0 V=1; done_count = 1.
- SUB 0x05 − 0x05, then SUB 0x00 − 0x01 back-to-back → first result 0x00 with N=0 Z=1 C=1 V=0; second result 0xFF with N=1 Z=0 C=0 V=0; outputs on consecutive cycles.
- AND 0xF0 & 0x0F, then OR 0xF0 | 0x0F → first result 0x00 with Z=1 C=0 V=0; second result 0xFF with N=1.
- Hold out_ready = 0 and offer 3 ops continuously → first two accepted; in_ready = 0 from the third offer on; out_result stable. Raise out_ready → all 3 emerge in order, one per cycle.
- Assert rst_n low while S1 and S2 are valid → immediately out_valid = 0, in_ready = 1, done_count = 0; no stale result appears after release.
- 2^CNT_W + 3 completed handshakes → done_count wraps and reads 3.
